// File: rtl/bus_err_drain.sv
// Drains bus-error FIFO records into a registered valid/ready stream, keeping a saturating error count,
// a sticky overflow flag and a coalesced interrupt. Fill latency is 1 cycle from pop to rec_valid_o.
// While a held record is not accepted the FIFO is not popped and rec_* stay stable.
module bus_err_drain #(
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned MetaDataWidth = 1,
    parameter int unsigned ErrBits       = 3,
    parameter int unsigned CntWidth      = 16,
    parameter int unsigned IrqThreshold  = 4,
    parameter int unsigned IrqTimeout    = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic                     err_irq_i,
    input  logic [ErrBits-1:0]       err_code_i,
    input  logic [AddrWidth-1:0]     err_addr_i,
    input  logic [MetaDataWidth-1:0] err_meta_i,
    input  logic                     err_fifo_overflow_i,
    output logic                     err_fifo_pop_o,
    output logic                     rec_valid_o,
    input  logic                     rec_ready_i,
    output logic [ErrBits-1:0]       rec_code_o,
    output logic [AddrWidth-1:0]     rec_addr_o,
    output logic [MetaDataWidth-1:0] rec_meta_o,
    output logic                     rec_overflow_o,
    output logic [CntWidth-1:0]      err_cnt_o,
    output logic                     overflow_o,
    input  logic                     cnt_clear_i,
    output logic                     irq_o,
    input  logic                     irq_clear_i
);

    localparam int unsigned PendWidth = $clog2(IrqThreshold + 1);
    localparam int unsigned TmrWidth  = (IrqTimeout > 1) ? $clog2(IrqTimeout) : 1;
    localparam bit          TimeoutEn = (IrqTimeout != 0);

    localparam logic [PendWidth-1:0] PendMax = PendWidth'(IrqThreshold);
    localparam logic [TmrWidth-1:0]  TmrLast = TmrWidth'(IrqTimeout - 1);
    localparam logic [CntWidth-1:0]  CntMax  = '1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t               state;
    logic                 capture;
    logic [PendWidth-1:0] pend_cnt;
    logic [PendWidth-1:0] pend_nxt;
    logic [TmrWidth-1:0]  timer;
    logic                 timer_run;
    logic                 irq_set;

    // A new head may be taken when the slot is empty or its record leaves this cycle.
    assign capture        = en_i & err_irq_i & ((state == EMPTY) | (rec_valid_o & rec_ready_i));
    assign err_fifo_pop_o = capture;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= EMPTY;
            rec_valid_o    <= 1'b0;
            rec_code_o     <= '0;
            rec_addr_o     <= '0;
            rec_meta_o     <= '0;
            rec_overflow_o <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (capture) begin
                        state       <= FULL;
                        rec_valid_o <= 1'b1;
                    end
                end
                FULL: begin
                    if (!capture && rec_ready_i) begin
                        state       <= EMPTY;
                        rec_valid_o <= 1'b0;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    rec_valid_o <= 1'b0;
                end
            endcase
            if (capture) begin
                rec_code_o     <= err_code_i;
                rec_addr_o     <= err_addr_i;
                rec_meta_o     <= err_meta_i;
                rec_overflow_o <= overflow_o | err_fifo_overflow_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_o  <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (cnt_clear_i) begin
                err_cnt_o <= capture ? CntWidth'(1) : '0;
            end else if (capture && err_cnt_o != CntMax) begin
                err_cnt_o <= err_cnt_o + CntWidth'(1);
            end
            if (err_fifo_overflow_i) begin
                overflow_o <= 1'b1;
            end else if (cnt_clear_i) begin
                overflow_o <= 1'b0;
            end
        end
    end

    // Clearing the interrupt restarts coalescing, counting a coincident capture as the first record.
    always_comb begin
        pend_nxt = pend_cnt;
        if (irq_clear_i) begin
            pend_nxt = capture ? PendWidth'(1) : '0;
        end else if (capture && pend_cnt != PendMax) begin
            pend_nxt = pend_cnt + PendWidth'(1);
        end
    end

    assign timer_run = TimeoutEn && (pend_cnt != '0) && !irq_o;
    assign irq_set   = (pend_nxt >= PendMax) || (timer_run && timer == TmrLast);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_cnt <= '0;
            timer    <= '0;
            irq_o    <= 1'b0;
        end else begin
            pend_cnt <= pend_nxt;
            if (irq_clear_i) begin
                timer <= '0;
            end else if (timer_run && timer != TmrLast) begin
                timer <= timer + TmrWidth'(1);
            end
            if (irq_clear_i) begin
                irq_o <= 1'b0;
            end else if (irq_set) begin
                irq_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_err_drain.sv
// Directed bench: a small FIFO model feeds two drains (16-bit count/timeout 8, and 2-bit count/no timeout).
module tb_bus_err_drain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        ready;
    logic        ovf;
    logic        cnt_clear;
    logic        irq_clear;

    logic [2:0]  m_code [32];
    logic [47:0] m_addr [32];
    logic [0:0]  m_meta [32];
    int          head = 0;
    int          tail = 0;

    logic        err_irq;
    logic [2:0]  err_code;
    logic [47:0] err_addr;
    logic [0:0]  err_meta;

    logic        a_pop, a_vld, a_rovf, a_ovf, a_irq;
    logic [2:0]  a_code;
    logic [47:0] a_addr;
    logic [0:0]  a_meta;
    logic [15:0] a_cnt;
    logic        b_pop, b_vld, b_rovf, b_ovf, b_irq;
    logic [2:0]  b_code;
    logic [47:0] b_addr;
    logic [0:0]  b_meta;
    logic [1:0]  b_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign err_irq  = (head != tail);
    assign err_code = m_code[head % 32];
    assign err_addr = m_addr[head % 32];
    assign err_meta = m_meta[head % 32];

    always @(posedge clk) if (a_pop) head <= head + 1;

    bus_err_drain #(.CntWidth(16), .IrqThreshold(4), .IrqTimeout(8)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .err_irq_i(err_irq),
        .err_code_i(err_code), .err_addr_i(err_addr), .err_meta_i(err_meta),
        .err_fifo_overflow_i(ovf), .err_fifo_pop_o(a_pop), .rec_valid_o(a_vld),
        .rec_ready_i(ready), .rec_code_o(a_code), .rec_addr_o(a_addr), .rec_meta_o(a_meta),
        .rec_overflow_o(a_rovf), .err_cnt_o(a_cnt), .overflow_o(a_ovf),
        .cnt_clear_i(cnt_clear), .irq_o(a_irq), .irq_clear_i(irq_clear)
    );

    bus_err_drain #(.CntWidth(2), .IrqThreshold(4), .IrqTimeout(0)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .err_irq_i(err_irq),
        .err_code_i(err_code), .err_addr_i(err_addr), .err_meta_i(err_meta),
        .err_fifo_overflow_i(ovf), .err_fifo_pop_o(b_pop), .rec_valid_o(b_vld),
        .rec_ready_i(ready), .rec_code_o(b_code), .rec_addr_o(b_addr), .rec_meta_o(b_meta),
        .rec_overflow_o(b_rovf), .err_cnt_o(b_cnt), .overflow_o(b_ovf),
        .cnt_clear_i(cnt_clear), .irq_o(b_irq), .irq_clear_i(irq_clear)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] c, input logic [47:0] a, input logic m);
        m_code[tail % 32] = c;
        m_addr[tail % 32] = a;
        m_meta[tail % 32] = m;
        tail = tail + 1;
    endtask

    task automatic clear_irq();
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; ready = 1'b0; ovf = 1'b0;
        cnt_clear = 1'b0; irq_clear = 1'b0;
        repeat (2) tick();
        chk("rst_vld", a_vld, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_irq", a_irq, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_pop", a_pop, 0);
        rst_n = 1'b1;
        tick();

        // three queued errors drain back to back
        en = 1'b1; ready = 1'b1;
        push(3'd1, 48'h0000_1000_0001, 1'b1);
        push(3'd2, 48'h0000_1000_0002, 1'b0);
        push(3'd3, 48'h0000_1000_0003, 1'b1);
        #1;
        chk("t1_pop0", a_pop, 1);
        chk("t1_pop0_b", b_pop, 1);
        tick();
        chk("t1_vld", a_vld, 1);
        chk("t1_code0", a_code, 1);
        chk("t1_addr0", a_addr, 48'h0000_1000_0001);
        chk("t1_meta0", a_meta, 1);
        chk("t1_pop1", a_pop, 1);
        tick();
        chk("t1_code1", a_code, 2);
        chk("t1_meta1", a_meta, 0);
        chk("t1_pop2", a_pop, 1);
        tick();
        chk("t1_code2", a_code, 3);
        chk("t1_addr2", a_addr, 48'h0000_1000_0003);
        chk("t1_pop3", a_pop, 0);
        chk("t1_rovf", a_rovf, 0);
        tick();
        chk("t1_vld_end", a_vld, 0);
        chk("t1_cnt", a_cnt, 3);
        chk("t1_cnt_b", b_cnt, 3);
        chk("t1_irq", a_irq, 0);
        clear_irq();

        // backpressure holds the record and stops popping
        ready = 1'b0;
        push(3'd4, 48'h0000_2000_0004, 1'b0);
        push(3'd5, 48'h0000_2000_0005, 1'b1);
        #1;
        chk("t2_pop0", a_pop, 1);
        tick();
        chk("t2_code0", a_code, 4);
        chk("t2_vld", a_vld, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_hold_code", a_code, 4);
            chk("t2_hold_addr", a_addr, 48'h0000_2000_0004);
            chk("t2_hold_pop", a_pop, 0);
        end
        chk("t2_irq_tmo", a_irq, 1);
        chk("t2_irq_b", b_irq, 0);
        ready = 1'b1;
        #1;
        chk("t2_pop1", a_pop, 1);
        tick();
        chk("t2_code1", a_code, 5);
        chk("t2_pop_empty", a_pop, 0);
        tick();
        chk("t2_vld_end", a_vld, 0);
        chk("t2_cnt", a_cnt, 5);
        chk("t2_cnt_sat_b", b_cnt, 3);
        clear_irq();
        chk("t2_irq_clr", a_irq, 0);

        // threshold interrupt after the fourth capture
        push(3'd6, 48'h0000_3000_0006, 1'b0);
        push(3'd7, 48'h0000_3000_0007, 1'b1);
        push(3'd1, 48'h0000_3000_0008, 1'b0);
        push(3'd2, 48'h0000_3000_0009, 1'b1);
        tick();
        tick();
        tick();
        chk("t3_irq3", a_irq, 0);
        chk("t3_irq3_b", b_irq, 0);
        tick();
        chk("t3_irq4", a_irq, 1);
        chk("t3_irq4_b", b_irq, 1);
        chk("t3_code4", a_code, 2);
        tick();
        push(3'd3, 48'h0000_3000_000a, 1'b0);
        irq_clear = 1'b1;
        #1;
        chk("t3_pop_clr", a_pop, 1);
        tick();
        irq_clear = 1'b0;
        chk("t3_irq_clr", a_irq, 0);
        chk("t3_irq_clr_b", b_irq, 0);
        push(3'd4, 48'h0000_3000_000b, 1'b0);
        push(3'd5, 48'h0000_3000_000c, 1'b0);
        push(3'd6, 48'h0000_3000_000d, 1'b0);
        tick();
        tick();
        chk("t3_pend3_b", b_irq, 0);
        tick();
        chk("t3_pend4_b", b_irq, 1);
        chk("t3_pend4", a_irq, 1);
        tick();
        chk("t3_cnt", a_cnt, 13);
        clear_irq();

        // timeout interrupt from a single record
        push(3'd7, 48'h0000_4000_0001, 1'b1);
        tick();
        chk("t4_irq0", a_irq, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("t4_tmo", a_irq, (i == 8) ? 1 : 0);
            chk("t4_tmo_off_b", b_irq, 0);
        end
        clear_irq();

        // counter clear coinciding with capture
        push(3'd1, 48'h0000_5000_0001, 1'b0);
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        chk("t5_clr_cap", a_cnt, 1);
        chk("t5_clr_cap_b", b_cnt, 1);
        cnt_clear = 1'b1;
        irq_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        irq_clear = 1'b0;
        chk("t5_clr", a_cnt, 0);

        // sticky overflow
        ovf = 1'b1;
        tick();
        ovf = 1'b0;
        chk("t6_ovf_set", a_ovf, 1);
        push(3'd2, 48'h0000_6000_0001, 1'b1);
        tick();
        chk("t6_rovf", a_rovf, 1);
        chk("t6_ovf_sticky", a_ovf, 1);
        tick();
        ovf = 1'b1;
        cnt_clear = 1'b1;
        tick();
        ovf = 1'b0;
        chk("t6_set_wins", a_ovf, 1);
        tick();
        cnt_clear = 1'b0;
        chk("t6_ovf_clr", a_ovf, 0);
        chk("t6_ovf_clr_b", b_ovf, 0);

        // disabled capture, held record, reset while full
        en = 1'b0;
        push(3'd3, 48'h0000_7000_0001, 1'b0);
        #1;
        chk("t7_en_pop", a_pop, 0);
        tick();
        chk("t7_en_vld", a_vld, 0);
        en = 1'b1;
        ready = 1'b0;
        #1;
        chk("t7_pop", a_pop, 1);
        tick();
        chk("t7_full", a_vld, 1);
        en = 1'b0;
        tick();
        chk("t7_held", a_vld, 1);
        chk("t7_held_code", a_code, 3);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_vld", a_vld, 0);
        chk("t7_rst_cnt", a_cnt, 0);
        chk("t7_rst_code", a_code, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
